// File: rtl/in12_pkg.sv
// Shared constants, scan state type and digit-count helper for the IN-12 nixie scan driver.
package in12_pkg;

  localparam logic [3:0] CATHODE_BLANK = 4'hF;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  // Decimal digits of the largest unsigned value of the given bit width (floor(w*log10(2)) + 1).
  function automatic int bcd_digits(input int width);
    return (width * 32'sd30103) / 32'sd100000 + 32'sd1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter; one bit per cycle, result held until the next run.
module bin2bcd_seq
  import in12_pkg::*;
#(
  parameter int IN_WIDTH   = 18,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Start,
  input  logic [IN_WIDTH-1:0]     Bin,
  output logic                    Busy,
  output logic [4*NUM_DIGITS-1:0] Bcd
);

  // The accumulator is sized so an oversized input can never carry out of the top digit.
  localparam int ACC_DIGITS = (bcd_digits(IN_WIDTH) > NUM_DIGITS) ? bcd_digits(IN_WIDTH) : NUM_DIGITS;
  localparam int ACC_W      = 4 * ACC_DIGITS;
  localparam int CNT_W      = $clog2(IN_WIDTH + 1);

  logic [IN_WIDTH-1:0]     shift_r;
  logic [ACC_W-1:0]        acc_r;
  logic [ACC_W-1:0]        adj_s;
  logic [CNT_W-1:0]        cnt_r;
  logic                    busy_r;
  logic [4*NUM_DIGITS-1:0] bcd_r;

  // Add-3 correction of every nibble that would overflow past 9 on the next shift.
  always_comb begin
    adj_s = acc_r;
    for (int i = 0; i < ACC_DIGITS; i++) begin
      if (acc_r[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = acc_r[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = acc_r[4*i +: 4];
      end
    end
  end

  // Capture, IN_WIDTH dabble iterations, then one commit cycle into the held result.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      shift_r <= {IN_WIDTH{1'b0}};
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      bcd_r   <= {(4*NUM_DIGITS){1'b0}};
    end else if (!busy_r) begin
      if (Start) begin
        shift_r <= Bin;
        acc_r   <= {ACC_W{1'b0}};
        cnt_r   <= {CNT_W{1'b0}};
        busy_r  <= 1'b1;
      end
    end else if (cnt_r == CNT_W'(IN_WIDTH)) begin
      bcd_r  <= acc_r[4*NUM_DIGITS-1:0];
      busy_r <= 1'b0;
    end else begin
      acc_r   <= ACC_W'({adj_s, shift_r[IN_WIDTH-1]});
      shift_r <= {shift_r[IN_WIDTH-2:0], 1'b0};
      cnt_r   <= cnt_r + CNT_W'(1'b1);
    end
  end

  assign Busy = busy_r;
  assign Bcd  = bcd_r;

endmodule

// File: rtl/in12_scan_driver.sv
// IN-12 nixie back-end: sequential BCD conversion of one counter value and a multiplexed,
// anti-ghosted, leading-zero-blanked tube scan with registered anode and cathode drive.
module in12_scan_driver
  import in12_pkg::*;
#(
  parameter int IN_WIDTH    = 18,
  parameter int NUM_DIGITS  = 6,
  parameter int DIGIT_TICKS = 2000,
  parameter int BLANK_TICKS = 200,
  parameter int LZB         = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [IN_WIDTH-1:0]   Value,
  input  logic                  Load,
  input  logic                  Enable,
  output logic                  Busy,
  output logic [NUM_DIGITS-1:0] Anodes,
  output logic [3:0]            Cathode
);

  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TICK_MAX = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  logic [4*NUM_DIGITS-1:0] disp_s;
  logic [3:0]              digit_s [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank_s;
  logic                    zero_run_s;

  scan_state_t             state_r, state_nxt;
  logic [TICK_W-1:0]       tick_r, tick_nxt;
  logic [IDX_W-1:0]        idx_r, idx_nxt;
  logic [NUM_DIGITS-1:0]   anodes_r, anodes_nxt;
  logic [3:0]              cathode_r, cathode_nxt;

  bin2bcd_seq #(
    .IN_WIDTH   (IN_WIDTH),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (Load),
    .Bin   (Value),
    .Busy  (Busy),
    .Bcd   (disp_s)
  );

  // Split the display register into digits; a digit is blank when it and everything above it is zero.
  always_comb begin
    zero_run_s = 1'b1;
    blank_s    = {NUM_DIGITS{1'b0}};
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      digit_s[k] = disp_s[4*k +: 4];
      zero_run_s = zero_run_s && (disp_s[4*k +: 4] == 4'd0);
      blank_s[k] = (LZB != 0) && (k > 0) && zero_run_s;
    end
  end

  // Scan state, dwell counter, slot index and registered tube drive.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r   <= BLANK;
      tick_r    <= {TICK_W{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
      anodes_r  <= {NUM_DIGITS{1'b0}};
      cathode_r <= CATHODE_BLANK;
    end else begin
      state_r   <= state_nxt;
      tick_r    <= tick_nxt;
      idx_r     <= idx_nxt;
      anodes_r  <= anodes_nxt;
      cathode_r <= cathode_nxt;
    end
  end

  // Slot sequencing: the cathode code is latched once on BLANK->ON so a display update never shows mid-slot.
  always_comb begin
    state_nxt   = state_r;
    tick_nxt    = tick_r;
    idx_nxt     = idx_r;
    anodes_nxt  = anodes_r;
    cathode_nxt = cathode_r;
    if (!Enable) begin
      state_nxt   = BLANK;
      tick_nxt    = {TICK_W{1'b0}};
      anodes_nxt  = {NUM_DIGITS{1'b0}};
      cathode_nxt = CATHODE_BLANK;
    end else begin
      case (state_r)
        BLANK: begin
          if (tick_r == TICK_W'(BLANK_TICKS - 1)) begin
            state_nxt = ON;
            tick_nxt  = {TICK_W{1'b0}};
            if (blank_s[idx_r]) begin
              anodes_nxt  = {NUM_DIGITS{1'b0}};
              cathode_nxt = CATHODE_BLANK;
            end else begin
              anodes_nxt  = NUM_DIGITS'(1'b1) << idx_r;
              cathode_nxt = digit_s[idx_r];
            end
          end else begin
            tick_nxt    = tick_r + TICK_W'(1'b1);
            anodes_nxt  = {NUM_DIGITS{1'b0}};
            cathode_nxt = CATHODE_BLANK;
          end
        end
        ON: begin
          if (tick_r == TICK_W'(DIGIT_TICKS - 1)) begin
            state_nxt   = BLANK;
            tick_nxt    = {TICK_W{1'b0}};
            anodes_nxt  = {NUM_DIGITS{1'b0}};
            cathode_nxt = CATHODE_BLANK;
            if (idx_r == IDX_W'(NUM_DIGITS - 1)) begin
              idx_nxt = {IDX_W{1'b0}};
            end else begin
              idx_nxt = idx_r + IDX_W'(1'b1);
            end
          end else begin
            tick_nxt = tick_r + TICK_W'(1'b1);
          end
        end
        default: begin
          state_nxt   = BLANK;
          tick_nxt    = {TICK_W{1'b0}};
          anodes_nxt  = {NUM_DIGITS{1'b0}};
          cathode_nxt = CATHODE_BLANK;
        end
      endcase
    end
  end

  assign Anodes  = anodes_r;
  assign Cathode = cathode_r;

endmodule

// File: tb/tb_in12_scan_driver.sv
// Self-checking bench for in12_scan_driver: directed and $urandom stimulus against a reference model
// that derives the tube drive from slot arithmetic on elapsed enabled cycles and decimal digit math.
module tb_in12_scan_driver;

  localparam int IW  = 18;
  localparam int ND  = 6;
  localparam int DT  = 4;
  localparam int BT  = 2;
  localparam int LZB = 1;
  localparam int P   = BT + DT;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b1;
  logic [IW-1:0] Value = '0;
  logic          Load = 1'b0;
  logic          Enable = 1'b1;
  logic          Busy;
  logic [ND-1:0] Anodes;
  logic [3:0]    Cathode;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int            m_disp, m_pending, m_left, m_e, m_base, m_lat_idx;
  logic [3:0]    m_lat_cath;
  bit            m_lat_blank;
  logic          m_busy;
  logic [ND-1:0] m_anodes;
  logic [3:0]    m_cathode;

  always #5 Clk = ~Clk;

  in12_scan_driver #(
    .IN_WIDTH(IW), .NUM_DIGITS(ND), .DIGIT_TICKS(DT), .BLANK_TICKS(BT), .LZB(LZB)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Value(Value), .Load(Load), .Enable(Enable),
    .Busy(Busy), .Anodes(Anodes), .Cathode(Cathode)
  );

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  task automatic model_reset();
    m_disp = 0; m_pending = 0; m_left = 0; m_e = 0; m_base = 0;
    m_lat_idx = 0; m_lat_cath = 4'hF; m_lat_blank = 1'b1;
    m_busy = 1'b0; m_anodes = '0; m_cathode = 4'hF;
  endtask

  // One clock edge of the model: scan uses the display value from before this edge's commit.
  task automatic model_edge();
    if (Enable !== 1'b1) begin
      m_base = (m_base + m_e / P) % ND;
      m_e = 0;
      m_anodes = '0; m_cathode = 4'hF;
    end else begin
      m_e = m_e + 1;
      if (m_e % P == BT) begin
        m_lat_idx   = (m_base + m_e / P) % ND;
        m_lat_blank = (LZB != 0) && (m_lat_idx > 0) && (m_disp < pow10(m_lat_idx));
        m_lat_cath  = 4'((m_disp / pow10(m_lat_idx)) % 10);
      end
      if ((m_e % P >= BT) && !m_lat_blank) begin
        m_anodes = '0; m_anodes[m_lat_idx] = 1'b1; m_cathode = m_lat_cath;
      end else begin
        m_anodes = '0; m_cathode = 4'hF;
      end
    end
    if (m_left == 0) begin
      if (Load === 1'b1) begin m_left = IW + 1; m_pending = int'(Value); end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) m_disp = m_pending;
    end
    m_busy = (m_left != 0);
  endtask

  task automatic tick();
    @(posedge Clk);
    if (Rst_n !== 1'b1) model_reset(); else model_edge();
    #1;
  endtask

  task automatic test_reset();
    Load = 1'b1; Enable = 1'b1; Value = IW'($urandom_range(0, (1 << IW) - 1));
    #1 Rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors += 3;
      if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy c=%0d got %b exp 0", c, Busy); end
      if (Anodes !== 6'b000000) begin miscompares++; $display("FAIL reset_anodes c=%0d got %b exp 000000", c, Anodes); end
      if (Cathode !== 4'hF) begin miscompares++; $display("FAIL reset_cathode c=%0d got %h exp f", c, Cathode); end
    end
    Load = 1'b0; Rst_n = 1'b1;
    for (int c = 0; c < P; c++) begin
      tick();
      vectors += 3;
      if (Busy !== m_busy) begin miscompares++; $display("FAIL post_reset_busy c=%0d got %b exp %b", c, Busy, m_busy); end
      if (Anodes !== m_anodes) begin miscompares++; $display("FAIL post_reset_anodes c=%0d got %b exp %b", c, Anodes, m_anodes); end
      if (Cathode !== m_cathode) begin miscompares++; $display("FAIL post_reset_cathode c=%0d got %h exp %h", c, Cathode, m_cathode); end
      if (c == BT - 1) begin
        vectors += 1;
        if (Anodes !== 6'b000001 || Cathode !== 4'h0) begin
          miscompares++; $display("FAIL first_slot got %b/%h exp 000001/0", Anodes, Cathode);
        end
      end
    end
  endtask

  task automatic test_conversion();
    int vals [5];
    int busy_cycles;
    vals[0] = 123456; vals[1] = 262143; vals[2] = 0;
    vals[3] = $urandom_range(0, (1 << IW) - 1); vals[4] = $urandom_range(0, 999);
    for (int t = 0; t < 5; t++) begin
      busy_cycles = 0;
      for (int c = 0; c < IW + 3 + ND * P; c++) begin
        Load = (c == 0);
        if (c == 0) Value = IW'(vals[t]);
        else if (c == 1) Value = IW'($urandom_range(0, (1 << IW) - 1));
        tick();
        if (Busy === 1'b1) busy_cycles++;
        vectors += 3;
        if (Busy !== m_busy) begin miscompares++; $display("FAIL conv_busy v=%0d c=%0d got %b exp %b", vals[t], c, Busy, m_busy); end
        if (Anodes !== m_anodes) begin miscompares++; $display("FAIL conv_anodes v=%0d c=%0d got %b exp %b", vals[t], c, Anodes, m_anodes); end
        if (Cathode !== m_cathode) begin miscompares++; $display("FAIL conv_cathode v=%0d c=%0d got %h exp %h", vals[t], c, Cathode, m_cathode); end
      end
      vectors += 1;
      if (busy_cycles != IW + 1) begin miscompares++; $display("FAIL busy_length v=%0d got %0d exp %0d", vals[t], busy_cycles, IW + 1); end
    end
  endtask

  task automatic test_scan_timing();
    int rises [$];
    logic prev_a0;
    for (int c = 0; c < IW + 2; c++) begin
      Load = (c == 0); if (c == 0) Value = IW'(654321);
      tick();
      vectors += 1;
      if (Busy !== m_busy) begin miscompares++; $display("FAIL scan_load_busy c=%0d got %b exp %b", c, Busy, m_busy); end
    end
    Load = 1'b0;
    prev_a0 = Anodes[0];
    for (int c = 0; c < 3 * ND * P; c++) begin
      tick();
      if (Anodes[0] === 1'b1 && prev_a0 !== 1'b1) rises.push_back(c);
      prev_a0 = Anodes[0];
      vectors += 3;
      if (!$onehot0(Anodes)) begin miscompares++; $display("FAIL scan_onehot c=%0d got %b exp onehot0", c, Anodes); end
      if (Anodes !== m_anodes) begin miscompares++; $display("FAIL scan_anodes c=%0d got %b exp %b", c, Anodes, m_anodes); end
      if (Cathode !== m_cathode) begin miscompares++; $display("FAIL scan_cathode c=%0d got %h exp %h", c, Cathode, m_cathode); end
    end
    vectors += 1;
    if (rises.size() < 2) begin
      miscompares++; $display("FAIL frame_period got %0d digit0 slots exp >=2", rises.size());
    end else if (rises[1] - rises[0] != ND * P) begin
      miscompares++; $display("FAIL frame_period got %0d exp %0d", rises[1] - rises[0], ND * P);
    end
  endtask

  task automatic test_load_during_busy();
    int rises [$];
    logic prev_busy;
    for (int c = 0; c < IW + 3 + ND * P; c++) begin
      Load = (c == 0 || c == 5);
      Value = (c == 5) ? IW'(222222) : IW'(111111);
      tick();
      vectors += 3;
      if (Busy !== m_busy) begin miscompares++; $display("FAIL ignore_busy c=%0d got %b exp %b", c, Busy, m_busy); end
      if (Anodes !== m_anodes) begin miscompares++; $display("FAIL ignore_anodes c=%0d got %b exp %b", c, Anodes, m_anodes); end
      if (Cathode !== m_cathode) begin miscompares++; $display("FAIL ignore_cathode c=%0d got %h exp %h", c, Cathode, m_cathode); end
    end
    prev_busy = Busy;
    Load = 1'b1;
    for (int c = 0; c < 3 * (IW + 2) + 2; c++) begin
      Value = IW'($urandom_range(0, (1 << IW) - 1));
      tick();
      if (Busy === 1'b1 && prev_busy !== 1'b1) rises.push_back(c);
      prev_busy = Busy;
      vectors += 2;
      if (Busy !== m_busy) begin miscompares++; $display("FAIL held_busy c=%0d got %b exp %b", c, Busy, m_busy); end
      if (Cathode !== m_cathode) begin miscompares++; $display("FAIL held_cathode c=%0d got %h exp %h", c, Cathode, m_cathode); end
    end
    Load = 1'b0;
    vectors += 1;
    if (rises.size() < 2) begin
      miscompares++; $display("FAIL held_spacing got %0d starts exp >=2", rises.size());
    end else if (rises[1] - rises[0] != IW + 2) begin
      miscompares++; $display("FAIL held_spacing got %0d exp %0d", rises[1] - rises[0], IW + 2);
    end
    repeat (IW + 2) tick();
  endtask

  task automatic test_lzb();
    int vals [2];
    int lit;
    vals[0] = 42; vals[1] = 0;
    for (int t = 0; t < 2; t++) begin
      lit = 0;
      for (int c = 0; c < IW + 2 + P + ND * P; c++) begin
        Load = (c == 0); Value = IW'(vals[t]);
        tick();
        if (c >= IW + 2 + P && Anodes !== 6'b000000) lit++;
        vectors += 2;
        if (Anodes !== m_anodes) begin miscompares++; $display("FAIL lzb_anodes v=%0d c=%0d got %b exp %b", vals[t], c, Anodes, m_anodes); end
        if (Cathode !== m_cathode) begin miscompares++; $display("FAIL lzb_cathode v=%0d c=%0d got %h exp %h", vals[t], c, Cathode, m_cathode); end
      end
      vectors += 1;
      if (lit != ((vals[t] == 0) ? DT : 2 * DT)) begin
        miscompares++; $display("FAIL lzb_lit_cycles v=%0d got %0d exp %0d", vals[t], lit, (vals[t] == 0) ? DT : 2 * DT);
      end
    end
    Load = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic [ND-1:0] saved_an;
    logic [3:0]    saved_cat;
    bit            found = 1'b0;
    for (int c = 0; c < IW + 2 + P; c++) begin
      Load = (c == 0); Value = IW'(987654);
      tick();
    end
    Load = 1'b0;
    for (int c = 0; c < 2 * P; c++) begin
      tick();
      vectors += 1;
      if (Anodes !== m_anodes) begin miscompares++; $display("FAIL en_pre_anodes c=%0d got %b exp %b", c, Anodes, m_anodes); end
      if (m_anodes != '0) begin found = 1'b1; break; end
    end
    vectors += 1;
    if (!found) begin miscompares++; $display("FAIL en_wait_lit got no lit slot exp one within %0d cycles", 2 * P); end
    tick();
    saved_an = m_anodes; saved_cat = m_cathode;
    Enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors += 2;
      if (Anodes !== 6'b000000) begin miscompares++; $display("FAIL en_off_anodes c=%0d got %b exp 000000", c, Anodes); end
      if (Cathode !== 4'hF) begin miscompares++; $display("FAIL en_off_cathode c=%0d got %h exp f", c, Cathode); end
    end
    Enable = 1'b1;
    for (int c = 0; c < BT + ND * P; c++) begin
      tick();
      vectors += 2;
      if (Anodes !== m_anodes) begin miscompares++; $display("FAIL en_on_anodes c=%0d got %b exp %b", c, Anodes, m_anodes); end
      if (Cathode !== m_cathode) begin miscompares++; $display("FAIL en_on_cathode c=%0d got %h exp %h", c, Cathode, m_cathode); end
      if (c == BT - 1) begin
        vectors += 1;
        if (Anodes !== saved_an || Cathode !== saved_cat) begin
          miscompares++; $display("FAIL en_same_idx got %b/%h exp %b/%h", Anodes, Cathode, saved_an, saved_cat);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 6; c++) begin
      Load = (c == 0); Value = IW'($urandom_range(1, (1 << IW) - 1));
      tick();
    end
    Load = 1'b0;
    Rst_n = 1'b0;
    #1;
    vectors += 3;
    if (Busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy got %b exp 0", Busy); end
    if (Anodes !== 6'b000000) begin miscompares++; $display("FAIL midreset_anodes got %b exp 000000", Anodes); end
    if (Cathode !== 4'hF) begin miscompares++; $display("FAIL midreset_cathode got %h exp f", Cathode); end
    model_reset();
    tick(); tick();
    Rst_n = 1'b1;
    for (int c = 0; c < ND * P + P; c++) begin
      tick();
      vectors += 3;
      if (Busy !== m_busy) begin miscompares++; $display("FAIL midreset_post_busy c=%0d got %b exp %b", c, Busy, m_busy); end
      if (Anodes !== m_anodes) begin miscompares++; $display("FAIL midreset_post_anodes c=%0d got %b exp %b", c, Anodes, m_anodes); end
      if (Cathode !== m_cathode) begin miscompares++; $display("FAIL midreset_post_cathode c=%0d got %h exp %h", c, Cathode, m_cathode); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1200; c++) begin
      Load  = ($urandom_range(0, 7) == 0);
      Value = IW'($urandom_range(0, (1 << IW) - 1));
      if ($urandom_range(0, 39) == 0) Enable = ~Enable;
      tick();
      vectors += 3;
      if (Busy !== m_busy) begin miscompares++; $display("FAIL rand_busy c=%0d got %b exp %b", c, Busy, m_busy); end
      if (Anodes !== m_anodes) begin miscompares++; $display("FAIL rand_anodes c=%0d got %b exp %b", c, Anodes, m_anodes); end
      if (Cathode !== m_cathode) begin miscompares++; $display("FAIL rand_cathode c=%0d got %h exp %h", c, Cathode, m_cathode); end
    end
    Enable = 1'b1;
    Load = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_conversion();
    test_scan_timing();
    test_load_during_busy();
    test_lzb();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
